// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// FSM states and the iterative latency helper.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Cycles from Start acceptance to the Done cycle for iterative ops.
  function automatic int iter_latency(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Single iteration of the shared datapath: shift-add for multiply,
// restoring shift-subtract for divide, on a 2*WIDTH accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 div_mode,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_nxt
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Multiply: acc = {partial, multiplier}. Divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    shifted = acc[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, opnd};
    if (div_mode) begin
      if (!diff[WIDTH]) acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else              acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {add_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine owning the architectural HI/LO registers,
// with Busy/Done handshake, divide-by-zero flag and flush abort.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Abort,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CNT_W = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg_d(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic op_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_q;
  logic               sign_a_q, sign_b_q, dbz_pend;
  logic               done_q, dbz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [WIDTH-1:0]   opnd;
  logic               accept, move, commit;

  logic [WIDTH-1:0]          mag_a, mag_b, quot, rem;
  logic                      neg;
  logic signed [2*WIDTH-1:0] prod_s, hilo, res;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (op_div(op_q)),
    .acc      (acc),
    .opnd     (opnd),
    .acc_nxt  (acc_step)
  );

  always_ff @(posedge Clk) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    move      = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start && !Abort) begin
          if (Op == OP_MTHI || Op == OP_MTLO) begin
            move = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = ST_ITER;
          end
        end
      end
      ST_ITER: begin
        if (Abort)            state_nxt = ST_IDLE;
        else if (cnt == '0)   state_nxt = ST_FIX;
      end
      ST_FIX: begin
        state_nxt = ST_IDLE;
        commit    = !Abort;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand conditioning and result fix-up (magnitudes in, signs restored at FIX).
  always_comb begin
    mag_a  = cneg_w(A, op_signed(Op) & A[WIDTH-1]);
    mag_b  = cneg_w(B, op_signed(Op) & B[WIDTH-1]);
    neg    = op_signed(op_q) & (sign_a_q ^ sign_b_q);
    prod_s = cneg_d(acc, neg);
    quot   = cneg_w(acc[WIDTH-1:0], neg);
    rem    = cneg_w(acc[2*WIDTH-1:WIDTH], op_signed(op_q) & sign_a_q);
    hilo   = {hi_q, lo_q};
    case (op_q)
      OP_MULT, OP_MULTU: res = prod_s;
      OP_DIV, OP_DIVU:   res = {rem, quot};
      OP_MADD:           res = hilo + prod_s;
      OP_MSUB:           res = hilo - prod_s;
      default:           res = hilo;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt      <= '0;
      op_q     <= OP_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dbz_pend <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= move | commit;
      dbz_q  <= commit & dbz_pend;
      if (accept) begin
        cnt      <= CNT_W'(WIDTH - 1);
        op_q     <= Op;
        sign_a_q <= A[WIDTH-1];
        sign_b_q <= B[WIDTH-1];
        dbz_pend <= op_div(Op) && (B == '0);
      end else if (state == ST_ITER && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (accept) begin
      acc  <= op_div(Op) ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
      opnd <= op_div(Op) ? mag_b : mag_a;
    end else if (state == ST_ITER) begin
      acc <= acc_step;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (move) begin
      if (Op == OP_MTHI) hi_q <= A;
      else               lo_q <= A;
    end else if (commit && !dbz_pend) begin
      {hi_q, lo_q} <= res;
    end
  end

  assign Busy      = (state != ST_IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32): directed ops push expected
// HI/LO/flag/Done-cycle; a monitor pops and checks on every Done pulse.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         Start = 1'b0;
  logic [2:0]   Op = 3'd0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Abort = 1'b0;
  logic         Busy, Done, DivByZero;
  logic [W-1:0] Hi, Lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B), .Abort(Abort),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic       dbz;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge Clk);
      if (!Rst && Done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: Done=1 with no pending op (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("hi", 64'(Hi), 64'(e.hi));
          chk("lo", 64'(Lo), 64'(e.lo));
          chk("divbyzero", 64'(DivByZero), 64'(e.dbz));
        end
      end else if (!Rst && DivByZero) begin
        n_cmp++;
        n_fail++;
        $display("FAIL dbz_without_done: DivByZero=1 Done=0 (cycle %0d)", cyc);
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                       input logic edbz);
    exp_t e;
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    if (push) begin
      e.cyc = (op == OP_MTHI || op == OP_MTLO) ? cyc : cyc + iter_latency(W) - 1;
      e.hi  = ehi;
      e.lo  = elo;
      e.dbz = edbz;
      sb.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt;
    fork
      monitor();
    join_none

    cycles(3);
    Rst = 1'b0;
    chk("rst_hi", 64'(Hi), 64'h0);
    chk("rst_lo", 64'(Lo), 64'h0);
    chk("rst_busy", 64'(Busy), 64'h0);
    chk("rst_done", 64'(Done), 64'h0);
    chk("rst_dbz", 64'(DivByZero), 64'h0);

    // MULT -2 * 3 = -6, with Busy duration check
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 1, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Busy) busy_cnt++;
    end
    chk("busy_cycles", 64'(busy_cnt), 64'd33);
    cycles(1);

    issue(OP_DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0);
    cycles(34);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    cycles(34);
    issue(OP_DIV, 32'd7, 32'hFFFFFFFE, 1, 32'd1, 32'hFFFFFFFD, 1'b0);
    cycles(34);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 32'h80000000, 1'b0);
    cycles(34);
    issue(OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, 1, 32'h0, 32'd15, 1'b0);
    cycles(34);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    cycles(34);

    // Moves then accumulate
    issue(OP_MTLO, 32'hFFFFFFFF, 32'd0, 1, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0);
    issue(OP_MTHI, 32'h0, 32'd0, 1, 32'h0, 32'hFFFFFFFF, 1'b0);
    issue(OP_MADD, 32'd1, 32'd1, 1, 32'd1, 32'd0, 1'b0);
    cycles(34);
    issue(OP_MSUB, 32'd1, 32'd1, 1, 32'd0, 32'hFFFFFFFF, 1'b0);
    cycles(34);

    // Divide by zero leaves HI/LO untouched
    issue(OP_MTHI, 32'h12345678, 32'd0, 1, 32'h12345678, 32'hFFFFFFFF, 1'b0);
    issue(OP_MTLO, 32'h12345678, 32'd0, 1, 32'h12345678, 32'h12345678, 1'b0);
    issue(OP_DIV, 32'd5, 32'd0, 1, 32'h12345678, 32'h12345678, 1'b1);
    cycles(34);

    // Abort at t+10 with an ignored Start at t+5
    issue(OP_MULTU, 32'd3, 32'd5, 0, '0, '0, 1'b0);
    cycles(4);
    chk("busy_mid", 64'(Busy), 64'h1);
    Start = 1'b1; Op = OP_MULT; A = 32'd9; B = 32'd9;
    cycles(1);
    Start = 1'b0;
    cycles(4);
    Abort = 1'b1;
    cycles(1);
    Abort = 1'b0;
    chk("abort_busy", 64'(Busy), 64'h0);
    cycles(40);
    chk("abort_hi", 64'(Hi), 64'h12345678);
    chk("abort_lo", 64'(Lo), 64'h12345678);

    // Back-to-back: second Start issued in the Done cycle of the first
    issue(OP_MULTU, 32'd2, 32'd3, 1, 32'd0, 32'd6, 1'b0);
    cycles(33);
    chk("b2b_done", 64'(Done), 64'h1);
    issue(OP_DIVU, 32'd9, 32'd4, 1, 32'd1, 32'd2, 1'b0);
    cycles(34);

    // Reset mid-ITER
    issue(OP_MULT, 32'd7, 32'd7, 0, '0, '0, 1'b0);
    cycles(10);
    Rst = 1'b1;
    cycles(1);
    Rst = 1'b0;
    chk("rst_mid_hi", 64'(Hi), 64'h0);
    chk("rst_mid_lo", 64'(Lo), 64'h0);
    chk("rst_mid_busy", 64'(Busy), 64'h0);
    cycles(40);

    chk("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
